// File: rtl/counter_step_sequencer_pkg.sv
// Shared definitions for the counter step sequencer: default sizes and FSM states.
package counter_step_sequencer_pkg;

  localparam int unsigned DefDepth  = 4;
  localparam int unsigned DefValW   = 4;
  localparam int unsigned DefDwellW = 8;
  localparam int unsigned ModeW     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/counter_step_sequencer_step_table.sv
// Step table: DEPTH entries of {mode, value, dwell}, one synchronous write port,
// one combinational read port, cleared by the asynchronous active-low reset.
module counter_step_sequencer_step_table
  import counter_step_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH  = DefDepth,
  parameter  int unsigned WIDTH  = ModeW + DefValW + DefDwellW,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: clear every entry on reset, otherwise take the write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/counter_step_sequencer.sv
// Step sequencer for the mod-N counter: walks a table of {mode, value, dwell}
// entries, loading the counter and enabling it for 'dwell' en_clk ticks per step.
module counter_step_sequencer
  import counter_step_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH   = DefDepth,
  parameter  int unsigned VAL_W   = DefValW,
  parameter  int unsigned DWELL_W = DefDwellW,
  localparam int unsigned ADDR_W  = $clog2(DEPTH),
  localparam int unsigned ENTRY_W = ModeW + VAL_W + DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [ADDR_W-1:0]  prog_len,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic               cnt_load,
  output logic [VAL_W-1:0]   cnt_val,
  output logic [1:0]         cnt_mode,
  output logic               cnt_en,
  output logic               busy,
  output logic [ADDR_W-1:0]  step,
  output logic               done
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    step_q, step_d;
  logic [ADDR_W-1:0]    len_q, len_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [VAL_W-1:0]     val_q, val_d;
  logic [1:0]           mode_q, mode_d;
  logic                 load_q, load_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 go_load;
  logic                 advance;
  logic                 dwell_dec;
  logic                 wr_accept;
  logic [ENTRY_W-1:0]   rd_data;
  logic [ENTRY_W-1:0]   entry;

  // Writes are only honoured while the sequencer is not running a program.
  assign wr_accept = wr_en && !busy_q;

  counter_step_sequencer_step_table #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_step_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (step_d),
    .rd_data (rd_data)
  );

  // FSM next state, step index and registered control outputs.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    len_d     = len_q;
    load_d    = 1'b0;
    en_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    go_load   = 1'b0;
    advance   = 1'b0;
    dwell_dec = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          len_d   = prog_len;
          step_d  = '0;
          go_load = 1'b1;
        end
      end
      StLoad: begin
        if (stop) begin
          state_d = StIdle;
          step_d  = '0;
        end else if (dwell_q != '0) begin
          state_d = StRun;
          busy_d  = 1'b1;
          en_d    = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      StRun: begin
        // stop wins over an advancing tick in the same cycle
        if (stop) begin
          state_d = StIdle;
          step_d  = '0;
        end else if (tick && dwell_q == DWELL_W'(1)) begin
          advance = 1'b1;
        end else begin
          busy_d    = 1'b1;
          en_d      = 1'b1;
          dwell_dec = tick;
        end
      end
      StDone: begin
        state_d = StIdle;
        step_d  = '0;
      end
      default: begin
        state_d = StIdle;
        step_d  = '0;
      end
    endcase

    if (advance) begin
      if (step_q != len_q) begin
        step_d  = step_q + 1'b1;
        go_load = 1'b1;
      end else if (loop_en) begin
        step_d  = '0;
        go_load = 1'b1;
      end else begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end

    if (go_load) begin
      state_d = StLoad;
      load_d  = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // Step entry capture and dwell countdown; a write landing on the entry being
  // loaded is forwarded so a start in the same cycle sees the new data.
  always_comb begin
    entry   = (wr_accept && (wr_addr == step_d)) ? wr_data : rd_data;
    val_d   = val_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    if (go_load) begin
      mode_d  = entry[ENTRY_W-1 -: ModeW];
      val_d   = entry[DWELL_W +: VAL_W];
      dwell_d = entry[DWELL_W-1:0];
    end else if (dwell_dec) begin
      dwell_d = dwell_q - 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      len_q   <= '0;
      dwell_q <= '0;
      val_q   <= '0;
      mode_q  <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      dwell_q <= dwell_d;
      val_q   <= val_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cnt_load = load_q;
  assign cnt_val  = val_q;
  assign cnt_mode = mode_q;
  assign cnt_en   = en_q;
  assign busy     = busy_q;
  assign step     = step_q;
  assign done     = done_q;

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Bench for counter_step_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the step program.
module tb_counter_step_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned VAL_W   = 4;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned ENTRY_W = 2 + VAL_W + DWELL_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               tick, start, stop, loop_en;
  logic [ADDR_W-1:0]  prog_len;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               cnt_load;
  logic [VAL_W-1:0]   cnt_val;
  logic [1:0]         cnt_mode;
  logic               cnt_en;
  logic               busy;
  logic [ADDR_W-1:0]  step;
  logic               done;

  always #5 clk = ~clk;

  counter_step_sequencer #(
    .DEPTH   (DEPTH),
    .VAL_W   (VAL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .prog_len (prog_len),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cnt_load (cnt_load),
    .cnt_val  (cnt_val),
    .cnt_mode (cnt_mode),
    .cnt_en   (cnt_en),
    .busy     (busy),
    .step     (step),
    .done     (done)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: the program as a table, the active step, and how many ticks remain.
  int tbl_mode [DEPTH];
  int tbl_val  [DEPTH];
  int tbl_dwell[DEPTH];
  bit m_busy, m_loading, m_finishing;
  int m_step, m_len, m_left, m_val, m_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input logic [1:0] m, input logic [3:0] v,
                                             input logic [7:0] d);
    return {m, v, d};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tbl_mode[i] = 0;
      tbl_val[i] = 0;
      tbl_dwell[i] = 0;
    end
    m_busy = 0;
    m_loading = 0;
    m_finishing = 0;
    m_step = 0;
    m_len = 0;
    m_left = 0;
    m_val = 0;
    m_mode = 0;
  endfunction

  function automatic void model_begin(input int s);
    m_step    = s;
    m_busy    = 1;
    m_loading = 1;
    m_val     = tbl_val[s];
    m_mode    = tbl_mode[s];
    m_left    = tbl_dwell[s];
  endfunction

  function automatic void model_advance();
    if (m_step < m_len) model_begin(m_step + 1);
    else if (loop_en) model_begin(0);
    else begin
      m_busy = 0;
      m_loading = 0;
      m_finishing = 1;
    end
  endfunction

  // One clock of the program as described: writes only when idle, then progress.
  function automatic void model_clock();
    bit was_busy;
    was_busy = m_busy;
    if (wr_en && !was_busy) begin
      tbl_mode[wr_addr]  = int'(wr_data[ENTRY_W-1 -: 2]);
      tbl_val[wr_addr]   = int'(wr_data[DWELL_W +: VAL_W]);
      tbl_dwell[wr_addr] = int'(wr_data[DWELL_W-1:0]);
    end
    if (!was_busy) begin
      if (m_finishing) begin
        m_finishing = 0;
        m_step = 0;
      end else if (start && !stop) begin
        m_len = int'(prog_len);
        model_begin(0);
      end
    end else if (stop) begin
      m_busy = 0;
      m_loading = 0;
      m_step = 0;
    end else if (m_loading) begin
      if (m_left == 0) model_advance();
      else m_loading = 0;
    end else if (tick) begin
      m_left--;
      if (m_left == 0) model_advance();
    end
  endfunction

  task automatic compare_model();
    check_eq("m_load", 32'(cnt_load), 32'(m_loading));
    check_eq("m_en",   32'(cnt_en),   32'(m_busy && !m_loading));
    check_eq("m_busy", 32'(busy),     32'(m_busy));
    check_eq("m_done", 32'(done),     32'(m_finishing));
    check_eq("m_step", 32'(step),     m_step);
    check_eq("m_val",  32'(cnt_val),  m_val);
    check_eq("m_mode", 32'(cnt_mode), m_mode);
  endtask

  // Inputs change at negedge; the model follows each posedge; outputs are
  // checked at the next negedge.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_model();
  endtask

  task automatic write_entry(input logic [ADDR_W-1:0] a, input logic [ENTRY_W-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    tick = 0; start = 0; stop = 0; loop_en = 0;
    prog_len = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_load", 32'(cnt_load), 0);
    check_eq("rst_en", 32'(cnt_en), 0);
    check_eq("rst_val", 32'(cnt_val), 0);
    reset = 1'b1;

    // Two-step program, no loop
    write_entry(2'd0, ent(2'd1, 4'd3, 8'd2));
    write_entry(2'd1, ent(2'd2, 4'd9, 8'd1));
    prog_len = 2'd1;
    pulse_start();
    check_eq("t2_load0", 32'(cnt_load), 1);
    check_eq("t2_val0", 32'(cnt_val), 3);
    check_eq("t2_mode0", 32'(cnt_mode), 1);
    check_eq("t2_en_load", 32'(cnt_en), 0);
    cycle();
    check_eq("t2_en_run", 32'(cnt_en), 1);
    tick = 1; cycle(); cycle(); tick = 0;
    check_eq("t2_load1", 32'(cnt_load), 1);
    check_eq("t2_val1", 32'(cnt_val), 9);
    check_eq("t2_mode1", 32'(cnt_mode), 2);
    check_eq("t2_step1", 32'(step), 1);
    cycle();
    tick = 1; cycle(); tick = 0;
    check_eq("t2_done", 32'(done), 1);
    check_eq("t2_busy_done", 32'(busy), 0);
    cycle();
    check_eq("t2_done_pulse", 32'(done), 0);
    check_eq("t2_step_idle", 32'(step), 0);

    // Looping program wraps to step 0
    loop_en = 1;
    pulse_start();
    cycle();
    tick = 1; cycle(); cycle(); tick = 0;
    cycle();
    tick = 1; cycle(); tick = 0;
    check_eq("t3_wrap_load", 32'(cnt_load), 1);
    check_eq("t3_wrap_val", 32'(cnt_val), 3);
    check_eq("t3_wrap_step", 32'(step), 0);
    check_eq("t3_no_done", 32'(done), 0);
    pulse_stop();
    check_eq("t3_stopped", 32'(busy), 0);
    loop_en = 0;

    // stop with the final tick
    pulse_start();
    cycle();
    tick = 1; cycle(); cycle(); tick = 0;
    cycle();
    tick = 1; stop = 1; cycle(); tick = 0; stop = 0;
    check_eq("t4_done", 32'(done), 0);
    check_eq("t4_en", 32'(cnt_en), 0);
    check_eq("t4_step", 32'(step), 0);
    cycle();
    check_eq("t4_done_late", 32'(done), 0);

    // Write while busy is dropped
    pulse_start();
    cycle();
    write_entry(2'd0, ent(2'd3, 4'd15, 8'd5));
    pulse_stop();
    pulse_start();
    check_eq("t5_val", 32'(cnt_val), 3);
    check_eq("t5_mode", 32'(cnt_mode), 1);
    pulse_stop();

    // Zero dwell: back-to-back loads
    write_entry(2'd0, ent(2'd1, 4'd3, 8'd0));
    pulse_start();
    check_eq("t6_load0", 32'(cnt_load), 1);
    check_eq("t6_en0", 32'(cnt_en), 0);
    cycle();
    check_eq("t6_load1", 32'(cnt_load), 1);
    check_eq("t6_val1", 32'(cnt_val), 9);
    check_eq("t6_en1", 32'(cnt_en), 0);

    // Write in the same cycle as start is seen by LOAD
    pulse_stop();
    wr_en = 1; wr_addr = 2'd0; wr_data = ent(2'd2, 4'd7, 8'd1);
    start = 1; cycle(); start = 0; wr_en = 0;
    check_eq("fwd_val", 32'(cnt_val), 7);
    pulse_stop();

    // start and stop together in IDLE
    start = 1; stop = 1; cycle(); start = 0; stop = 0;
    check_eq("ss_busy", 32'(busy), 0);

    // Asynchronous reset while running
    write_entry(2'd0, ent(2'd1, 4'd3, 8'd4));
    pulse_start();
    cycle();
    check_eq("t1_en_pre", 32'(cnt_en), 1);
    reset = 1'b0;
    #1;
    check_eq("t1_en", 32'(cnt_en), 0);
    check_eq("t1_busy", 32'(busy), 0);
    check_eq("t1_val", 32'(cnt_val), 0);
    check_eq("t1_mode", 32'(cnt_mode), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(); cycle();
    check_eq("t1_idle", 32'(busy), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick     = ($urandom_range(0, 2) == 0);
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0) loop_en = !loop_en;
      prog_len = ADDR_W'($urandom_range(0, 3));
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = ADDR_W'($urandom_range(0, 3));
      wr_data  = ent(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 3)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
